// File: rtl/pn_pkg.sv
// Shared constants and types for the PN sequence generator family.
package pn_pkg;

    // Widest LFSR the generator is meant to be built with.
    localparam int PN_N_MAX = 16;

    // Primitive Fibonacci tap masks (bit i set -> s[i] feeds the XOR).
    localparam logic [4:0] PN_POLY_5 = 5'b10100;        // x^5 + x^3 + 1
    localparam logic [6:0] PN_POLY_7 = 7'b1100000;      // x^7 + x^6 + 1
    localparam logic [8:0] PN_POLY_9 = 9'b100010000;    // x^9 + x^5 + 1

    // Registered per-chip output flags.
    typedef struct packed {
        logic pn;
        logic valid;
        logic epoch;
        logic lockup;
    } pn_flags_t;

    // Maximal-length period of an n-bit LFSR.
    function automatic int unsigned pn_period(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/pn_seq_gen_if.sv
// Control/observation bundle of the PN generator: enable, seed load and
// the registered chip stream.
interface pn_seq_gen_if #(
    parameter int N = 5
) ();
    logic         en;
    logic         load;
    logic [N-1:0] seed;
    logic         pn;
    logic         pn_valid;
    logic         epoch;
    logic         lockup;
    logic [N-1:0] state;

    // Consumer side: drives control, observes the chip stream.
    modport master (
        output en, load, seed,
        input  pn, pn_valid, epoch, lockup, state
    );

    // Generator side.
    modport slave (
        input  en, load, seed,
        output pn, pn_valid, epoch, lockup, state
    );
endinterface

// File: rtl/pn_chip_div.sv
// Chip-rate divider: one tick every DIV enabled clocks, synchronous clear.
module pn_chip_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    // Tick on the last count of an enabled clock; DIV=1 makes tick follow en.
    assign tick_o = en_i & (cnt_q == DIV_LAST);

    // Count enabled clocks, wrap on tick, clear takes priority.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (tick_o)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pn_seq_gen.sv
// Parametrised Fibonacci LFSR PN chip generator with chip-rate divider,
// seed load, period marker and all-zero lock-up recovery.
module pn_seq_gen
    import pn_pkg::*;
#(
    parameter int           N            = 5,                      // 3..16
    parameter logic [N-1:0] POLY         = PN_POLY_5,
    parameter logic [N-1:0] SEED_DEFAULT = {{(N-1){1'b0}}, 1'b1},  // nonzero
    parameter int           DIV          = 1                       // 1..65535
) (
    input  logic         clk,
    input  logic         rst_n,
    pn_seq_gen_if.slave  bus
);
    // Last chip index of a period; chip_cnt wraps to 0 after it.
    localparam logic [N-1:0] CHIP_LAST = N'(pn_period(N) - 1);

    logic [N-1:0] s_q, s_d;
    logic [N-1:0] chip_q, chip_d;
    pn_flags_t    out_q, out_d;

    logic         fb;
    logic [N-1:0] next_s;
    logic         s_zero;
    logic         seed_zero;
    logic [N-1:0] seed_eff;
    logic         clr;
    logic         tick;
    logic         adv;

    assign fb        = ^(s_q & POLY);
    assign next_s    = {s_q[N-2:0], fb};
    assign s_zero    = (s_q == '0);
    assign seed_zero = (bus.seed == '0);
    assign seed_eff  = seed_zero ? SEED_DEFAULT : bus.seed;

    // A load or a lock-up recovery restarts the chip timing from scratch.
    assign clr = bus.load | s_zero;
    assign adv = tick & ~clr;

    pn_chip_div #(
        .DIV (DIV)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (bus.en),
        .clr_i  (clr),
        .tick_o (tick)
    );

    // Next state: load beats recovery beats a chip advance; pn holds otherwise.
    always_comb begin
        s_d          = s_q;
        chip_d       = chip_q;
        out_d        = '0;
        out_d.pn     = out_q.pn;
        if (bus.load) begin
            s_d          = seed_eff;
            chip_d       = '0;
            out_d.lockup = seed_zero;
        end else if (s_zero) begin
            s_d          = SEED_DEFAULT;
            chip_d       = '0;
            out_d.lockup = 1'b1;
        end else if (adv) begin
            s_d         = next_s;
            chip_d      = (chip_q == CHIP_LAST) ? '0 : chip_q + 1'b1;
            out_d.pn    = s_q[N-1];
            out_d.valid = 1'b1;
            out_d.epoch = (chip_q == '0);
        end
    end

    // State, chip counter and output flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= SEED_DEFAULT;
            chip_q <= '0;
            out_q  <= '0;
        end else begin
            s_q    <= s_d;
            chip_q <= chip_d;
            out_q  <= out_d;
        end
    end

    assign bus.pn       = out_q.pn;
    assign bus.pn_valid = out_q.valid;
    assign bus.epoch    = out_q.epoch;
    assign bus.lockup   = out_q.lockup;
    assign bus.state    = s_q;

endmodule

// File: tb/tb_pn_seq_gen.sv
// Self-checking bench for pn_seq_gen: a DIV=1 and a DIV=4 instance sharing
// the same control inputs, directed sequences plus a random scoreboard run.
module tb_pn_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, load;
    logic [4:0] seed;

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    pn_seq_gen_if #(.N(5)) ifa ();
    pn_seq_gen_if #(.N(5)) ifb ();

    assign ifa.en = en;  assign ifa.load = load;  assign ifa.seed = seed;
    assign ifb.en = en;  assign ifb.load = load;  assign ifb.seed = seed;

    pn_seq_gen #(.N(5), .POLY(5'b10100), .SEED_DEFAULT(5'd1), .DIV(1)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa)
    );
    pn_seq_gen #(.N(5), .POLY(5'b10100), .SEED_DEFAULT(5'd1), .DIV(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the chip stream of x^5+x^3+1 obeys b[n] = b[n-5]^b[n-3],
    // where the first five bits are the seed read MSB first; the state after k
    // chips is b[k..k+4].
    bit   str [2][1024];
    int   len [2];
    int   kc  [2];
    int   ec  [2];
    logic pnx [2];

    task automatic m_load(input int i, input logic [4:0] sd);
        for (int j = 0; j < 5; j++) str[i][j] = sd[4-j];
        len[i] = 5; kc[i] = 0; ec[i] = 0;
    endtask

    task automatic m_ensure(input int i, input int j);
        while (len[i] <= j) begin
            str[i][len[i]] = str[i][len[i]-5] ^ str[i][len[i]-3];
            len[i]++;
        end
    endtask

    task automatic m_step(input int i, input int d, input logic e, input logic ld,
                          input logic [4:0] sd, output logic [8:0] exp);
        logic v, ep, lk;
        logic [4:0] st;
        v = 0; ep = 0; lk = 0;
        if (ld) begin
            lk = (sd == 0);
            m_load(i, (sd == 0) ? 5'd1 : sd);
        end else if (e) begin
            ec[i]++;
            if (ec[i] == d) begin
                ec[i] = 0;
                m_ensure(i, kc[i]);
                v = 1; pnx[i] = str[i][kc[i]];
                ep = (kc[i] % 31 == 0);
                kc[i]++;
            end
        end
        m_ensure(i, kc[i] + 4);
        for (int j = 0; j < 5; j++) st[4-j] = str[i][kc[i]+j];
        exp = {pnx[i], v, ep, lk, st};
    endtask

    typedef struct {
        logic       en, load;
        logic [4:0] seed;
        logic       chk_pn;
        logic       pn, valid, epoch, lockup;
        logic [4:0] state;
    } vec_t;

    vec_t vt [10];

    logic       ch [64];
    logic       eb [64];
    int         ones, neps, gap_at, found;
    logic [8:0] ea, eb9;
    logic [4:0] sd_r;
    logic       en_r, ld_r;
    logic       prev_pnb;

    initial begin
        // Load sequence on the DIV=1 instance: load/tick collision, chips
        // 1,0,1,1,0, enable hold, zero-seed load, restart at chip 0.
        vt[0] = '{1, 1, 5'b10110, 0, 0, 0, 0, 0, 5'b10110};
        vt[1] = '{1, 0, 5'b00000, 1, 1, 1, 1, 0, 5'b01100};
        vt[2] = '{1, 0, 5'b00000, 1, 0, 1, 0, 0, 5'b11001};
        vt[3] = '{1, 0, 5'b00000, 1, 1, 1, 0, 0, 5'b10011};
        vt[4] = '{1, 0, 5'b00000, 1, 1, 1, 0, 0, 5'b00111};
        vt[5] = '{1, 0, 5'b00000, 1, 0, 1, 0, 0, 5'b01111};
        vt[6] = '{0, 0, 5'b00000, 1, 0, 0, 0, 0, 5'b01111};
        vt[7] = '{1, 1, 5'b00000, 1, 0, 0, 0, 1, 5'b00001};
        vt[8] = '{1, 0, 5'b00000, 1, 0, 1, 1, 0, 5'b00010};
        vt[9] = '{1, 0, 5'b00000, 1, 0, 1, 0, 0, 5'b00100};

        rst_n = 0; en = 0; load = 0; seed = '0;
        #12;
        chk("rst_a", {ifa.pn, ifa.pn_valid, ifa.epoch, ifa.lockup, ifa.state}, {4'b0000, 5'd1});
        chk("rst_b", {ifb.pn, ifb.pn_valid, ifb.epoch, ifb.lockup, ifb.state}, {4'b0000, 5'd1});
        rst_n = 1; en = 1;

        // Free run from reset.
        neps = 0; prev_pnb = ifb.pn;
        for (int c = 1; c <= 40; c++) begin
            step();
            ch[c-1] = ifa.pn; eb[c-1] = ifa.epoch;
            if (ifa.epoch) neps++;
            if (ifa.pn_valid !== 1'b1) chk("a_valid_every", ifa.pn_valid, 1);
            chk("b_valid_div4", ifb.pn_valid, (c % 4 == 0));
            if (!ifb.pn_valid) chk("b_pn_stable", ifb.pn, prev_pnb);
            prev_pnb = ifb.pn;
        end
        begin
            logic [9:0] exp10, got10;
            exp10 = 10'b0000100101;
            for (int j = 0; j < 10; j++) got10[9-j] = ch[j];
            chk("first10_chips", got10, exp10);
        end
        chk("epoch_chip1", eb[0], 1);
        chk("epoch_chip32", eb[31], 1);
        chk("epoch_count40", neps, 2);
        ones = 0;
        for (int j = 0; j < 31; j++) ones += ch[j];
        chk("ones_per_period", ones, 16);

        // DIV=4: three disabled clocks stretch the pulse spacing by three.
        gap_at = 0;
        for (int c = 41; c <= 52; c++) begin
            en = !(c >= 43 && c <= 45);
            step();
            if (ifb.pn_valid && gap_at == 0) gap_at = c;
        end
        chk("b_gap_with_en_low", gap_at, 47);
        en = 1;

        // Table-driven load sequence.
        foreach (vt[r]) begin
            en = vt[r].en; load = vt[r].load; seed = vt[r].seed;
            step();
            chk($sformatf("tbl%0d_valid", r), ifa.pn_valid, vt[r].valid);
            chk($sformatf("tbl%0d_epoch", r), ifa.epoch, vt[r].epoch);
            chk($sformatf("tbl%0d_lockup", r), ifa.lockup, vt[r].lockup);
            chk($sformatf("tbl%0d_state", r), ifa.state, vt[r].state);
            if (vt[r].chk_pn) chk($sformatf("tbl%0d_pn", r), ifa.pn, vt[r].pn);
        end
        en = 1; load = 0;

        // Upset the state to zero between edges.
        @(negedge clk);
        force dut_a.s_q = 5'd0;
        #1;
        release dut_a.s_q;
        chk("force_state0", ifa.state, 0);
        step();
        chk("recov_state", ifa.state, 1);
        chk("recov_lockup", ifa.lockup, 1);
        chk("recov_novalid", ifa.pn_valid, 0);
        step();
        chk("recov_after", {ifa.pn, ifa.pn_valid, ifa.epoch, ifa.lockup}, 4'b0110);

        // Asynchronous reset while a load and a tick are pending.
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (ifa.pn_valid && ifa.pn) found = 1;
        end
        chk("find_pn1", found, 1);
        load = 1; seed = 5'd0; en = 1;
        #3;
        rst_n = 0;
        #1;
        chk("async_rst_a", {ifa.pn, ifa.pn_valid, ifa.epoch, ifa.lockup, ifa.state}, {4'b0000, 5'd1});
        chk("async_rst_b", {ifb.pn_valid, ifb.epoch, ifb.lockup, ifb.state}, {3'b000, 5'd1});
        @(negedge clk);
        rst_n = 1; load = 0;
        begin
            logic [4:0] exp5, got5;
            exp5 = 5'b00001;
            for (int j = 0; j < 5; j++) begin
                step();
                got5[4-j] = ifa.pn;
                if (j == 0) chk("restart_epoch", ifa.epoch, 1);
            end
            chk("restart_chips", got5, exp5);
        end

        // Random control against the reference model.
        rst_n = 0; en = 0; load = 0;
        step();
        rst_n = 1;
        m_load(0, 5'd1); m_load(1, 5'd1); pnx[0] = 0; pnx[1] = 0;
        for (int c = 0; c < 400; c++) begin
            en_r = ($urandom % 4) != 0;
            ld_r = ($urandom % 20) == 0;
            sd_r = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
            en = en_r; load = ld_r; seed = sd_r;
            step();
            m_step(0, 1, en_r, ld_r, sd_r, ea);
            m_step(1, 4, en_r, ld_r, sd_r, eb9);
            chk("rand_a", {ifa.pn, ifa.pn_valid, ifa.epoch, ifa.lockup, ifa.state}, ea);
            chk("rand_b", {ifb.pn, ifb.pn_valid, ifb.epoch, ifb.lockup, ifb.state}, eb9);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
